// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: FSM encoding, line geometry
// and address-field offsets used by the cache, the CPU top and the memory model.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    localparam int ADDR_W         = 32;
    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS      = 256;
    localparam int WORDS_PER_LINE = LINE_BITS / WORD_BITS;
    localparam int WORD_LSB       = 2;
    localparam int WORD_SEL_W     = 3;
    localparam int INDEX_LSB      = 5;

    function automatic logic [WORD_BITS-1:0] get_word(
        input logic [LINE_BITS-1:0]  line,
        input logic [WORD_SEL_W-1:0] sel
    );
        return line[sel*WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: combinational read,
// word-write port for store hits and a line-fill port for refills.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = ADDR_W - INDEX_LSB - IDX_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [LINE_BITS-1:0]  o_rd_line,
    input  logic                  i_word_we,
    input  logic [IDX_W-1:0]      i_word_idx,
    input  logic [WORD_SEL_W-1:0] i_word_sel,
    input  logic [WORD_BITS-1:0]  i_word_data,
    input  logic                  i_fill_we,
    input  logic [IDX_W-1:0]      i_fill_idx,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic [LINE_BITS-1:0]  i_fill_line
);

    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    // Only the status bits are reset; tag/data contents are don't-care while invalid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_fill_idx] <= 1'b1;
            r_dirty[i_fill_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_word_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill_we) begin
            r_tag[i_fill_idx]  <= i_fill_tag;
            r_data[i_fill_idx] <= i_fill_line;
        end else if (i_word_we) begin
            r_data[i_word_idx][i_word_sel*WORD_BITS +: WORD_BITS] <= i_word_data;
        end
    end

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data-cache controller: direct-mapped, write-back, write-allocate,
// with whole-line write-back and refill over a req/ack memory handshake.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_LSB = INDEX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    state_t r_state;
    state_t w_next_state;

    logic [31:WORD_LSB]   r_addr;
    logic                 r_we;
    logic [WORD_BITS-1:0] r_wdata;

    logic [TAG_W-1:0]      w_cpu_tag;
    logic [IDX_W-1:0]      w_cpu_idx;
    logic [WORD_SEL_W-1:0] w_cpu_sel;
    logic [TAG_W-1:0]      w_lat_tag;
    logic [IDX_W-1:0]      w_lat_idx;
    logic [WORD_SEL_W-1:0] w_lat_sel;

    logic [IDX_W-1:0]     w_rd_idx;
    logic [TAG_W-1:0]     w_rd_tag;
    logic                 w_rd_valid;
    logic                 w_rd_dirty;
    logic [LINE_BITS-1:0] w_rd_line;

    logic                  w_hit;
    logic                  w_miss;
    logic                  w_word_we;
    logic [IDX_W-1:0]      w_word_idx;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic [WORD_BITS-1:0]  w_word_data;
    logic                  w_fill_we;
    logic                  w_unused;

    assign w_cpu_tag = cpu_addr_i[31:TAG_LSB];
    assign w_cpu_idx = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
    assign w_cpu_sel = cpu_addr_i[INDEX_LSB-1:WORD_LSB];
    assign w_lat_tag = r_addr[31:TAG_LSB];
    assign w_lat_idx = r_addr[TAG_LSB-1:INDEX_LSB];
    assign w_lat_sel = r_addr[INDEX_LSB-1:WORD_LSB];
    assign w_unused  = ^cpu_addr_i[WORD_LSB-1:0];

    // Outside IDLE the arrays are addressed by the latched miss, not the live CPU bus.
    assign w_rd_idx    = (r_state == S_IDLE) ? w_cpu_idx : w_lat_idx;
    assign w_hit       = w_rd_valid & (w_rd_tag == w_cpu_tag);
    assign w_miss      = cpu_req_i & ~w_hit;
    assign cpu_stall_o = (r_state != S_IDLE) | w_miss;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_rd_idx    (w_rd_idx),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_dirty  (w_rd_dirty),
        .o_rd_line   (w_rd_line),
        .i_word_we   (w_word_we),
        .i_word_idx  (w_word_idx),
        .i_word_sel  (w_word_sel),
        .i_word_data (w_word_data),
        .i_fill_we   (w_fill_we),
        .i_fill_idx  (w_lat_idx),
        .i_fill_tag  (w_lat_tag),
        .i_fill_line (mem_rdata_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if ((r_state == S_IDLE) && w_miss) begin
            r_addr  <= cpu_addr_i[31:WORD_LSB];
            r_we    <= cpu_we_i;
            r_wdata <= cpu_wdata_i;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_next_state = (w_rd_valid & w_rd_dirty) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    w_next_state = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // A latched store is merged during REFILL so it lands even if the CPU withdraws the request.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        cpu_rdata_o = '0;
        w_fill_we   = 1'b0;
        w_word_we   = 1'b0;
        w_word_idx  = w_cpu_idx;
        w_word_sel  = w_cpu_sel;
        w_word_data = cpu_wdata_i;
        case (r_state)
            S_IDLE: begin
                if (cpu_req_i && w_hit) begin
                    if (cpu_we_i) begin
                        w_word_we = 1'b1;
                    end else begin
                        cpu_rdata_o = get_word(w_rd_line, w_cpu_sel);
                    end
                end
            end
            S_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {w_rd_tag, w_lat_idx, {INDEX_LSB{1'b0}}};
                mem_wdata_o = w_rd_line;
            end
            S_ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {w_lat_tag, w_lat_idx, {INDEX_LSB{1'b0}}};
                w_fill_we  = mem_ack_i;
            end
            S_REFILL: begin
                if (r_we) begin
                    w_word_we   = 1'b1;
                    w_word_idx  = w_lat_idx;
                    w_word_sel  = w_lat_sel;
                    w_word_data = r_wdata;
                end
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a reference cache model plus an in-bench
// memory image answer each miss, and expected load data is queued at issue.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst;
    logic         cpuReq;
    logic         cpuWe;
    logic [31:0]  cpuAddr;
    logic [31:0]  cpuWdata;
    logic [31:0]  cpuRdata;
    logic         cpuStall;
    logic         memReq;
    logic         memWe;
    logic [31:0]  memAddr;
    logic [255:0] memWdata;
    logic [255:0] memRdata;
    logic         memAck;

    int total = 0;
    int bad   = 0;

    logic [31:0]  sb [$];
    logic [255:0] memImg [logic [31:0]];

    logic         mValid [16];
    logic         mDirty [16];
    logic [22:0]  mTag   [16];
    logic [255:0] mLine  [16];

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpuReq),
        .cpu_we_i    (cpuWe),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_rdata_o (cpuRdata),
        .cpu_stall_o (cpuStall),
        .mem_req_o   (memReq),
        .mem_we_o    (memWe),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata),
        .mem_ack_i   (memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [255:0] fetchLine(input logic [31:0] la);
        logic [255:0] line;
        logic [2:0]   ws;
        if (memImg.exists(la)) return memImg[la];
        line = '0;
        for (int w = 0; w < 8; w++) begin
            ws = w[2:0];
            line[w*32 +: 32] = {8'hA5, la[15:0], 5'd0, ws};
        end
        return line;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i]   = '0;
            mLine[i]  = '0;
        end
    endtask

    // Wait for a memory request, check it, hold it for 'delay' cycles, then ack.
    task automatic serveMem(input logic expWe, input logic [31:0] expAddr,
                            input logic [255:0] data, input int delay);
        int n = 0;
        while (memReq !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (memReq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mem_req_timeout: got=%b want=1", memReq);
        end
        total++;
        if (memWe !== expWe || memAddr !== expAddr) begin
            bad++;
            $display("[TB] FAIL mem_cmd: got we=%b addr=%h want we=%b addr=%h", memWe, memAddr, expWe, expAddr);
        end
        if (expWe) begin
            total++;
            if (memWdata !== data) begin
                bad++;
                $display("[TB] FAIL mem_wdata: got=%h want=%h", memWdata, data);
            end
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); #1;
            total++;
            if (memReq !== 1'b1 || memWe !== expWe || memAddr !== expAddr ||
                (expWe && memWdata !== data) || cpuStall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL mem_hold: cycle=%0d got req=%b we=%b addr=%h stall=%b want req=1 we=%b addr=%h stall=1",
                         i, memReq, memWe, memAddr, cpuStall, expWe, expAddr);
            end
        end
        memAck   = 1'b1;
        memRdata = expWe ? {8{32'hBAD0_BAD0}} : data;
        @(negedge clk);
        memAck   = 1'b0;
        memRdata = '0;
        #1;
    endtask

    // One CPU access, served to completion, checked against the reference model.
    task automatic doAccess(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int delay);
        logic [3:0]   idx;
        logic [22:0]  tag;
        int           w;
        bit           miss;
        logic [255:0] line;
        logic [31:0]  exp;
        idx  = addr[8:5];
        tag  = addr[31:9];
        w    = int'(addr[4:2]);
        miss = !(mValid[idx] && mTag[idx] == tag);
        line = miss ? fetchLine({addr[31:5], 5'd0}) : mLine[idx];
        @(negedge clk);
        cpuReq   = 1'b1;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = wdata;
        if (!we) sb.push_back(line[w*32 +: 32]);
        #1;
        total++;
        if (cpuStall !== logic'(miss)) begin
            bad++;
            $display("[TB] FAIL issue_stall addr=%h: got=%b want=%b", addr, cpuStall, miss);
        end
        if (miss) begin
            if (mValid[idx] && mDirty[idx]) begin
                serveMem(1'b1, {mTag[idx], idx, 5'd0}, mLine[idx], delay);
                memImg[{mTag[idx], idx, 5'd0}] = mLine[idx];
            end
            serveMem(1'b0, {addr[31:5], 5'd0}, line, delay);
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mTag[idx]   = tag;
            mLine[idx]  = line;
            total++;
            if (cpuStall !== 1'b1 || memReq !== 1'b0) begin
                bad++;
                $display("[TB] FAIL refill_cycle addr=%h: got stall=%b req=%b want stall=1 req=0", addr, cpuStall, memReq);
            end
            @(negedge clk); #1;
        end
        total++;
        if (cpuStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL complete_stall addr=%h: got=%b want=0", addr, cpuStall);
        end
        if (!we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL scoreboard_empty addr=%h: got=%h want=queued value", addr, cpuRdata);
            end else begin
                exp = sb.pop_front();
                if (cpuRdata !== exp) begin
                    bad++;
                    $display("[TB] FAIL load_data addr=%h: got=%h want=%h", addr, cpuRdata, exp);
                end
            end
        end else begin
            mLine[idx][w*32 +: 32] = wdata;
            mDirty[idx] = 1'b1;
        end
        @(negedge clk);
        cpuReq = 1'b0;
        cpuWe  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || cpuStall !== 1'b0 || cpuRdata !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got req=%b we=%b stall=%b rdata=%h want 0 0 0 0",
                     memReq, memWe, cpuStall, cpuRdata);
        end
        cpuReq  = 1'b1;
        cpuAddr = 32'h40;
        #1;
        total++;
        if (cpuStall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_stall_with_req: got=%b want=1", cpuStall);
        end
        cpuReq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    task automatic test_clean_miss();
        logic [255:0] line;
        line = fetchLine(32'h40);
        line[31:0] = 32'hDEADBEEF;
        memImg[32'h40] = line;
        doAccess(1'b0, 32'h40, 32'h0, 0);
    endtask

    task automatic test_store_hit();
        doAccess(1'b1, 32'h44, 32'h12345678, 0);
        doAccess(1'b0, 32'h44, 32'h0, 0);
    endtask

    task automatic test_dirty_evict();
        doAccess(1'b0, 32'h240, 32'h0, 2);
        total++;
        if (memImg[32'h40][63:32] !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL writeback_word1: got=%h want=12345678", memImg[32'h40][63:32]);
        end
    endtask

    task automatic test_slow_memory();
        doAccess(1'b1, 32'h244, 32'hCAFEF00D, 0);
        doAccess(1'b0, 32'h44, 32'h0, 10);
    endtask

    task automatic test_reset_mid_alloc();
        int n = 0;
        @(negedge clk);
        cpuReq  = 1'b1;
        cpuWe   = 1'b0;
        cpuAddr = 32'h640;
        #1;
        while (memReq !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h640) begin
            bad++;
            $display("[TB] FAIL alloc_before_reset: got req=%b we=%b addr=%h want 1 0 00000640", memReq, memWe, memAddr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || cpuStall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_abort: got req=%b we=%b stall=%b want 0 0 1", memReq, memWe, cpuStall);
        end
        cpuReq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        doAccess(1'b0, 32'h40, 32'h0, 1);
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        cpuReq   = 1'b0;
        memAck   = 1'b1;
        memRdata = {8{32'h5555_5555}};
        #1;
        total++;
        if (memReq !== 1'b0 || cpuStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL spurious_ack_during: got req=%b stall=%b want 0 0", memReq, cpuStall);
        end
        @(negedge clk);
        memAck   = 1'b0;
        memRdata = '0;
        #1;
        total++;
        if (memReq !== 1'b0 || cpuStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL spurious_ack_after: got req=%b stall=%b want 0 0", memReq, cpuStall);
        end
        doAccess(1'b0, 32'h40, 32'h0, 0);
        doAccess(1'b0, 32'h44, 32'h0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        cpuReq   = 1'b0;
        cpuWe    = 1'b0;
        cpuAddr  = '0;
        cpuWdata = '0;
        memRdata = '0;
        memAck   = 1'b0;
        clearModel();
        test_reset();
        test_clean_miss();
        test_store_hit();
        test_dirty_evict();
        test_slow_memory();
        test_reset_mid_alloc();
        test_spurious_ack();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
